// File: rtl/mac_seq_ctrl.sv
// Frame sequencer for the matrix-multiply datapath: load X/A, run the ALU, drain
// write-back, pulse done. Includes abort, a LOAD/COMPUTE watchdog and a frame counter.
module mac_seq_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int WDOG_W       = 10,
    parameter int FRAME_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               xload_done,
    input  logic               aload_done,
    input  logic               ALU_done,
    output logic               input_load_en,
    output logic               ALU_en,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         state,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    // Trip one count early so the state lasts exactly 2**WDOG_W-1 cycles before ERR.
    localparam logic [WDOG_W-1:0] WDOG_TRIP = {{(WDOG_W-1){1'b1}}, 1'b0};

    state_t            cur_state;
    state_t            nxt_state;
    logic              x_flag;
    logic              a_flag;
    logic [DW-1:0]     drain_cnt;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_trip;

    assign wdog_trip = (wdog_cnt == WDOG_TRIP);

    always_comb begin
        nxt_state = cur_state;
        if (abort) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE:    if (start) nxt_state = S_LOAD;
                S_LOAD: begin
                    if (x_flag && a_flag) nxt_state = S_COMPUTE;
                    else if (wdog_trip)   nxt_state = S_ERR;
                end
                S_COMPUTE: begin
                    if (ALU_done)       nxt_state = S_DRAIN;
                    else if (wdog_trip) nxt_state = S_ERR;
                end
                S_DRAIN:   if (drain_cnt == '0) nxt_state = S_DONE;
                S_DONE:    nxt_state = start ? S_LOAD : S_IDLE;
                S_ERR:     nxt_state = S_ERR;
                default:   nxt_state = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state     <= S_IDLE;
            x_flag        <= 1'b0;
            a_flag        <= 1'b0;
            drain_cnt     <= '0;
            wdog_cnt      <= '0;
            frame_cnt     <= '0;
            input_load_en <= 1'b0;
            ALU_en        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            state         <= 3'd0;
        end else begin
            cur_state <= nxt_state;
            x_flag    <= (cur_state == S_LOAD) && (x_flag || xload_done);
            a_flag    <= (cur_state == S_LOAD) && (a_flag || aload_done);

            if (nxt_state != cur_state)
                wdog_cnt <= '0;
            else if (cur_state == S_LOAD || cur_state == S_COMPUTE)
                wdog_cnt <= wdog_cnt + 1'b1;

            if (nxt_state == S_DRAIN && cur_state != S_DRAIN)
                drain_cnt <= DRAIN_LOAD;
            else if (cur_state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;

            if (nxt_state == S_DONE)
                frame_cnt <= frame_cnt + 1'b1;

            input_load_en <= (nxt_state == S_LOAD);
            ALU_en        <= (nxt_state == S_COMPUTE);
            busy          <= (nxt_state == S_LOAD) || (nxt_state == S_COMPUTE) ||
                             (nxt_state == S_DRAIN);
            done          <= (nxt_state == S_DONE);
            err           <= (nxt_state == S_ERR);
            state         <= nxt_state;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed frames with a done/frame_cnt scoreboard, plus a
// second instance with a short watchdog.
module tb_mac_seq_ctrl;

    localparam int DRAIN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, abort, xload_done, aload_done, alu_done;
    logic       input_load_en, alu_en, busy, done, err;
    logic [2:0] state;
    logic [1:0] frame_cnt;
    logic       wd_input_load_en, wd_alu_en, wd_busy, wd_done, wd_err;
    logic [2:0] wd_state;
    logic [1:0] wd_frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    typedef struct {
        int         at;
        logic [1:0] fc;
    } exp_t;
    exp_t sb[$];
    exp_t head;

    mac_seq_ctrl #(.DRAIN_CYCLES(DRAIN), .WDOG_W(10), .FRAME_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .xload_done(xload_done), .aload_done(aload_done), .ALU_done(alu_done),
        .input_load_en(input_load_en), .ALU_en(alu_en), .busy(busy), .done(done),
        .err(err), .state(state), .frame_cnt(frame_cnt)
    );

    mac_seq_ctrl #(.DRAIN_CYCLES(DRAIN), .WDOG_W(4), .FRAME_W(2)) dut_wd (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .xload_done(xload_done), .aload_done(aload_done), .ALU_done(alu_done),
        .input_load_en(wd_input_load_en), .ALU_en(wd_alu_en), .busy(wd_busy), .done(wd_done),
        .err(wd_err), .state(wd_state), .frame_cnt(wd_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Scoreboard monitor: every done pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && cyc > sb[0].at) begin
                head = sb.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missed_done: done absent, expected done at cycle %0d", head.at);
            end
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_done: done at cycle %0d frame_cnt=%0d, required no done",
                             cyc, frame_cnt);
                end else begin
                    head = sb.pop_front();
                    if (cyc != head.at || frame_cnt != head.fc) begin
                        errors++;
                        $display("[TB] FAIL done_frame: cycle %0d frame_cnt=%0d, required cycle %0d frame_cnt=%0d",
                                 cyc, frame_cnt, head.at, head.fc);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic x, input logic a,
                                 input logic d, input logic ab);
        start      = s;
        xload_done = x;
        aload_done = a;
        alu_done   = d;
        abort      = ab;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (rel cycle %0d)",
                     name, actual, expected, cyc - t0);
        end
    endtask

    task automatic at_cycle(input int c);
        repeat (t0 + c - cyc) @(negedge clk);
    endtask

    task automatic reset_dut(input bit full);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        if (full) begin
            checkOutput("rst_load_en", input_load_en, 0);
            checkOutput("rst_alu_en", alu_en, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_err", err, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        #1;
        reset_dut(1'b1);

        $display("[TB] T1/T6 single frame with spurious inputs");
        applyStimulus(0, 0, 0, 1, 0);
        at_cycle(1);
        checkOutput("t6_alu_done_idle", state, 0);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(2);
        t0 = cyc;
        applyStimulus(1, 0, 0, 0, 0);
        at_cycle(1);
        checkOutput("t1_load_state", state, 1);
        checkOutput("t1_load_en", input_load_en, 1);
        checkOutput("t1_load_busy", busy, 1);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(3);  applyStimulus(0, 0, 1, 0, 0);
        at_cycle(4);  applyStimulus(0, 0, 0, 0, 0);
        at_cycle(5);  applyStimulus(0, 0, 0, 1, 0);
        at_cycle(6);
        checkOutput("t6_alu_done_load", state, 1);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(10);
        checkOutput("t1_wait_x", state, 1);
        applyStimulus(0, 1, 0, 0, 0);
        at_cycle(11);
        checkOutput("t1_last_load", state, 1);
        checkOutput("t1_last_load_alu_en", alu_en, 0);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(12);
        checkOutput("t1_compute_state", state, 2);
        checkOutput("t1_compute_alu_en", alu_en, 1);
        checkOutput("t1_compute_load_en", input_load_en, 0);
        at_cycle(20); applyStimulus(1, 0, 0, 0, 0);
        at_cycle(21);
        checkOutput("t6_start_compute", state, 2);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(40);
        applyStimulus(0, 0, 0, 1, 0);
        sb.push_back('{at: t0 + 40 + DRAIN + 1, fc: 2'd1});
        at_cycle(41);
        checkOutput("t1_drain_state", state, 3);
        checkOutput("t1_drain_alu_en", alu_en, 0);
        checkOutput("t1_drain_busy", busy, 1);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(46);
        checkOutput("t1_end_state", state, 0);
        checkOutput("t1_end_frame_cnt", frame_cnt, 1);
        checkOutput("t1_end_busy", busy, 0);

        $display("[TB] T5 async reset mid-COMPUTE");
        t0 = cyc;
        applyStimulus(1, 0, 0, 0, 0);
        at_cycle(1); applyStimulus(0, 1, 1, 0, 0);
        at_cycle(2); applyStimulus(0, 0, 0, 0, 0);
        at_cycle(3);
        checkOutput("t5_compute_state", state, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_async_state", state, 0);
        checkOutput("t5_async_alu_en", alu_en, 0);
        checkOutput("t5_async_busy", busy, 0);
        checkOutput("t5_async_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;

        $display("[TB] T2/T5 back-to-back frames with wrap");
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            at_cycle(10 * k + 1); applyStimulus(1, 1, 1, 0, 0);
            at_cycle(10 * k + 2);
            checkOutput("t2_load_state", state, 1);
            applyStimulus(1, 0, 0, 0, 0);
            at_cycle(10 * k + 3);
            checkOutput("t2_compute_state", state, 2);
            checkOutput("t2_compute_alu_en", alu_en, 1);
            at_cycle(10 * k + 5);
            applyStimulus(1, 0, 0, 1, 0);
            sb.push_back('{at: t0 + 10 * k + 10, fc: 2'((k + 1) % 4)});
            at_cycle(10 * k + 6); applyStimulus(1, 0, 0, 0, 0);
        end
        at_cycle(40); applyStimulus(0, 0, 0, 0, 0);
        at_cycle(41);
        checkOutput("t2_end_state", state, 0);
        checkOutput("t2_wrap_frame_cnt", frame_cnt, 0);

        $display("[TB] T3 watchdog");
        reset_dut(1'b0);
        applyStimulus(1, 0, 0, 0, 0);
        at_cycle(1); applyStimulus(0, 1, 1, 0, 0);
        at_cycle(2); applyStimulus(0, 0, 0, 0, 0);
        at_cycle(17);
        checkOutput("t3_last_compute", wd_state, 2);
        checkOutput("t3_err_before", wd_err, 0);
        at_cycle(18);
        checkOutput("t3_err_state", wd_state, 5);
        checkOutput("t3_err_flag", wd_err, 1);
        checkOutput("t3_err_alu_en", wd_alu_en, 0);
        checkOutput("t3_err_busy", wd_busy, 0);
        checkOutput("t3_long_wdog_compute", state, 2);
        at_cycle(20); applyStimulus(0, 0, 0, 0, 1);
        at_cycle(21);
        checkOutput("t3_abort_state", wd_state, 0);
        checkOutput("t3_abort_err", wd_err, 0);
        checkOutput("t3_abort_main_state", state, 0);
        checkOutput("t3_abort_frame_cnt", frame_cnt, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] T4 abort");
        at_cycle(23);
        t0 = cyc;
        applyStimulus(1, 0, 0, 0, 0);
        at_cycle(1); applyStimulus(0, 0, 0, 0, 0);
        at_cycle(2); applyStimulus(0, 0, 0, 0, 1);
        at_cycle(3);
        checkOutput("t4_abort_load_state", state, 0);
        checkOutput("t4_abort_load_en", input_load_en, 0);
        applyStimulus(1, 0, 0, 0, 1);
        at_cycle(4);
        checkOutput("t4_abort_start_idle", state, 0);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(6);
        t0 = cyc;
        applyStimulus(1, 0, 0, 0, 0);
        at_cycle(1); applyStimulus(0, 1, 1, 0, 0);
        at_cycle(2); applyStimulus(0, 0, 0, 0, 0);
        at_cycle(4); applyStimulus(0, 0, 0, 1, 0);
        at_cycle(5);
        checkOutput("t4_drain_state", state, 3);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(6); applyStimulus(0, 0, 0, 0, 1);
        at_cycle(7);
        checkOutput("t4_abort_drain_state", state, 0);
        checkOutput("t4_abort_drain_busy", busy, 0);
        checkOutput("t4_abort_frame_cnt", frame_cnt, 0);
        applyStimulus(0, 0, 0, 0, 0);
        at_cycle(12);
        checkOutput("t4_no_done", done, 0);

        checkOutput("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
